// File: rtl/prefix_adder_pipe.sv
// ============================================================================
// Module   : prefix_adder_pipe
// Purpose  : Pipelined Kogge-Stone parallel-prefix adder, sum = a + b + cin,
//            with carry-out and valid/ready flow control. Latency is
//            1 + ceil($clog2(WIDTH)/REG_EVERY) cycles when not stalled.
// Options  : Define PREFIX_ADDER_SUB_EN to add a 'sub' input that computes
//            a + ~b + 1 (co=1 means no borrow).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prefix_adder_pipe #(
  parameter int WIDTH     = 22,
  parameter int REG_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PREFIX_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int NGRP   = (LEVELS + REG_EVERY - 1) / REG_EVERY;

  // Per-stage views of the pipeline registers. Index 0 is the operand
  // stage, index NGRP is the final stage feeding sum/co.
  logic [NGRP:0]             stg_v;
  logic [NGRP:0]             stg_c;
  logic [NGRP:0][WIDTH-1:0]  stg_p;   // original propagate bits, needed for the sum XOR
  logic [NGRP:0][WIDTH-1:0]  stg_g;   // prefix generate (carry out of bit i)
  logic [NGRP-1:0][WIDTH-1:0] stg_pp; // prefix propagate, not needed after the last level

  logic             w_advance;
  logic [WIDTH-1:0] w_b;
  logic             w_c;
  logic [WIDTH-1:0] w_p0;
  logic [WIDTH-1:0] w_g0;

  // Whole pipe moves together; it only stalls when a result is waiting.
  assign w_advance = ~stg_v[NGRP] | out_ready;
  assign in_ready  = w_advance;

`ifdef PREFIX_ADDER_SUB_EN
  // Subtract as a + ~b + 1; the incoming carry is ignored in that mode.
  assign w_b = sub ? ~b : b;
  assign w_c = sub | cin;
`else
  assign w_b = b;
  assign w_c = cin;
`endif

  // The carry-in is folded into bit 0's generate so that WIDTH prefix
  // positions suffice; the prefix span of $clog2(WIDTH) levels then reaches
  // the carry-in from every bit, including the top one.
  assign w_p0 = a ^ w_b;
  assign w_g0 = (a & w_b) | {{(WIDTH-1){1'b0}}, w_p0[0] & w_c};

  // Operand stage: capture propagate, generate and carry-in.
  logic             v0_q;
  logic             c0_q;
  logic [WIDTH-1:0] p0_q;
  logic [WIDTH-1:0] g0_q;

  // Operand stage register, loads on every advance (bubbles included).
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q <= 1'b0;
      c0_q <= 1'b0;
      p0_q <= '0;
      g0_q <= '0;
    end else if (w_advance) begin
      v0_q <= in_valid;
      c0_q <= w_c;
      p0_q <= w_p0;
      g0_q <= w_g0;
    end
  end

  assign stg_v[0]  = v0_q;
  assign stg_c[0]  = c0_q;
  assign stg_p[0]  = p0_q;
  assign stg_g[0]  = g0_q;
  assign stg_pp[0] = p0_q;

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    localparam int LO = k * REG_EVERY;
    localparam int HI = (LO + REG_EVERY < LEVELS) ? (LO + REG_EVERY) : LEVELS;

    logic [WIDTH-1:0] g_d;
    logic [WIDTH-1:0] pp_d;
    logic             v_q;
    logic             c_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] g_q;

    // Prefix levels LO..HI-1: bit i combines with bit i-2^l; the low 2^l
    // bits already span down to bit 0 (and the carry-in) and pass through.
    always_comb begin
      g_d  = stg_g[k];
      pp_d = stg_pp[k];
      for (int l = LO; l < HI; l++) begin
        g_d  = g_d | (pp_d & (g_d << (1 << l)));
        pp_d = pp_d & ((pp_d << (1 << l)) | ~({WIDTH{1'b1}} << (1 << l)));
      end
    end

    // Group register: valid, carry-in, original propagate and prefix generate.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        p_q <= '0;
        g_q <= '0;
      end else if (w_advance) begin
        v_q <= stg_v[k];
        c_q <= stg_c[k];
        p_q <= stg_p[k];
        g_q <= g_d;
      end
    end

    assign stg_v[k+1] = v_q;
    assign stg_c[k+1] = c_q;
    assign stg_p[k+1] = p_q;
    assign stg_g[k+1] = g_q;

    if (k < NGRP - 1) begin : g_pp
      logic [WIDTH-1:0] pp_q;

      // Prefix propagate is only carried forward while levels remain.
      always_ff @(posedge clk) begin
        if (rst) begin
          pp_q <= '0;
        end else if (w_advance) begin
          pp_q <= pp_d;
        end
      end

      assign stg_pp[k+1] = pp_q;
    end
  end

  // Results come only from final-stage registers.
  assign out_valid = stg_v[NGRP];
  assign sum       = stg_p[NGRP] ^ {stg_g[NGRP][WIDTH-2:0], stg_c[NGRP]};
  assign co        = stg_g[NGRP][WIDTH-1];

endmodule

`default_nettype wire

// File: tb/tb_prefix_adder_pipe.sv
// ============================================================================
// Module   : tb_prefix_adder_pipe
// Purpose  : Self-checking bench for prefix_adder_pipe (WIDTH=22 default
//            instance plus a WIDTH=8, REG_EVERY=1 instance).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prefix_adder_pipe;

  localparam int W   = 22;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         co;

  logic         iv8;
  logic         ir8;
  logic [7:0]   a8;
  logic [7:0]   b8;
  logic         cin8;
  logic         ov8;
  logic [7:0]   sum8;
  logic         co8;
`ifdef PREFIX_ADDER_SUB_EN
  logic         sub8 = 1'b0;
`endif

  always #5 clk = ~clk;

  prefix_adder_pipe #(.WIDTH(W), .REG_EVERY(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PREFIX_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co)
  );

  prefix_adder_pipe #(.WIDTH(8), .REG_EVERY(1)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
`ifdef PREFIX_ADDER_SUB_EN
    .sub       (sub8),
`endif
    .out_valid (ov8),
    .out_ready (1'b1),
    .sum       (sum8),
    .co        (co8)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [W:0] sb[$];
  logic [W:0] held;
  logic       hold_ok = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    logic [W:0] r;
    if (s) r = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
    else   r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every handshake and checks that a
  // stalled result holds with in_ready low.
  always @(negedge clk) begin
    if (rst) begin
      hold_ok = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) chk("result", 64'({co, sum}), 64'(sb.pop_front()));
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        if (hold_ok) chk("stall_stable", 64'({co, sum}), 64'(held));
        held    = {co, sum};
        hold_ok = 1'b1;
      end else begin
        hold_ok = 1'b0;
      end
    end
  end

  // Present one beat, wait (bounded) for acceptance, record the expectation.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic c, input logic s);
    int t;
    t        = 0;
    in_valid = 1'b1;
    a        = x;
    b        = y;
    cin      = c;
    sub      = s;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    chk("accept_timeout", 64'(t < 50), 64'd1);
    sb.push_back(model(x, y, c, s));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic c,
                      input logic [7:0] esum, input logic eco);
    int n;
    iv8  = 1'b1;
    a8   = x;
    b8   = y;
    cin8 = c;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    n   = 1;
    while (!ov8 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("w8_latency", 64'(n), 64'd4);
    chk("w8_sum", 64'(sum8), 64'(esum));
    chk("w8_co", 64'(co8), 64'(eco));
  endtask

  task automatic drain();
    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int c0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_co", 64'(co), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed carry ripple through all bits, with latency and pulse width.
    send(22'h3FFFFF, 22'h0, 1'b1, 1'b0);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(LAT));
    chk("dir_sum", 64'(sum), 64'h0);
    chk("dir_co", 64'(co), 64'd1);
    @(posedge clk);
    #1;
    chk("single_pulse", 64'(out_valid), 64'd0);
    drain();

    // Back-to-back random stream.
    c0 = cyc;
    for (int i = 0; i < 100; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    end
    chk("stream_cycles", 64'(cyc - c0), 64'd100);
    drain();

    // Boundary patterns.
    send(22'h3FFFFF, 22'h3FFFFF, 1'b1, 1'b0);
    send(22'h200000, 22'h200000, 1'b0, 1'b0);
    send(22'h0, 22'h0, 1'b0, 1'b0);
    send(22'h155555, 22'h2AAAAA, 1'b1, 1'b0);
    drain();

    // Stall the output for five cycles mid-stream.
    fork
      begin
        send(22'h000123, 22'h000456, 1'b0, 1'b0);
        send(22'h3FF000, 22'h001000, 1'b1, 1'b0);
        send(22'h0ABCDE, 22'h154321, 1'b0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight.
    send(22'h000011, 22'h000022, 1'b0, 1'b0);
    send(22'h000033, 22'h000044, 1'b1, 1'b0);
    send(22'h000055, 22'h000066, 1'b0, 1'b0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_sum", 64'(sum), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    send(22'h000005, 22'h000006, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_drained", 64'(sb.size()), 64'd0);

`ifdef PREFIX_ADDER_SUB_EN
    send(22'd5, 22'd7, 1'b0, 1'b1);
    send(22'd7, 22'd5, 1'b1, 1'b1);
    drain();
`endif

    // Narrow instance, one level per register group.
    run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    run8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    run8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
